// File: rtl/axi_stream_remove_header.sv
// rtl/axi_stream_remove_header.sv - strips N leading bytes per packet and re-packs the payload MSB-first
//
// Purpose: for each packet, takes a strip count N from the command port and
// drops the first N bytes of the packet. It then re-aligns the remaining
// payload so that every non-last beat is full. The last beat carries
// contiguous, MSB-aligned keep bits. There is a single registered output stage.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   valid_in/data_in/keep_in/last_in    input stream; ready_in is its backpressure
//   valid_remove/byte_remove_cnt        per-packet strip command; ready_remove acknowledges it
//   valid_out/data_out/keep_out/last_out output stream; ready_out is its backpressure
//   header_out/header_valid             stripped header bytes (only with HEADER_CAPTURE_EN)
//
// Optional feature macro: HEADER_CAPTURE_EN
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
  output logic                    ready_remove,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef HEADER_CAPTURE_EN
  ,
  output logic [DATA_WD-1:0]      header_out,
  output logic                    header_valid
`endif
);

  localparam logic [BYTE_CNT_WD:0] LP_BYTES = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_STREAM, S_FLUSH} state_t;

  // m MSB-first ones in a keep vector
  function automatic logic [DATA_BYTE_WD-1:0] f_keep(input logic [BYTE_CNT_WD:0] m);
    f_keep = ~({DATA_BYTE_WD{1'b1}} >> m);
  endfunction

  // expand byte enables to a bit mask
  function automatic logic [DATA_WD-1:0] f_bits(input logic [DATA_BYTE_WD-1:0] k);
    f_bits = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) f_bits[8*i +: 8] = {8{k[i]}};
  endfunction

  state_t                  r_state;
  logic [BYTE_CNT_WD:0]    r_n;
  logic [DATA_WD-1:0]      r_res;         // residue, MSB-aligned, R bytes valid
  logic [DATA_WD-1:0]      r_flush_data;
  logic [DATA_BYTE_WD-1:0] r_flush_keep;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;
`ifdef HEADER_CAPTURE_EN
  logic [DATA_WD-1:0]      r_header;
  logic                    r_header_valid;
`endif

  logic                    w_out_free;
  logic                    w_in_fire;
  logic [BYTE_CNT_WD:0]    w_r;
  logic [BYTE_CNT_WD:0]    w_k;
  logic [BYTE_CNT_WD:0]    w_sum;
  logic [BYTE_CNT_WD:0]    w_n_clamp;
  logic [BYTE_CNT_WD+3:0]  w_sh_n;
  logic [BYTE_CNT_WD+3:0]  w_sh_r;
  logic [DATA_WD-1:0]      w_din_m;
  logic [DATA_WD-1:0]      w_join;
  logic [DATA_WD-1:0]      w_tail;
  logic                    w_emit;
  logic [DATA_WD-1:0]      w_odata;
  logic [DATA_BYTE_WD-1:0] w_okeep;
  logic                    w_olast;

  assign w_out_free   = ready_out | ~r_valid_out;
  assign ready_in     = ((r_state == S_FIRST) || (r_state == S_STREAM)) && w_out_free;
  assign ready_remove = (r_state == S_IDLE);
  assign w_in_fire    = valid_in & ready_in;
  assign w_n_clamp    = (byte_remove_cnt > LP_BYTES) ? LP_BYTES : byte_remove_cnt;
  assign w_r          = LP_BYTES - r_n;
  assign w_sum        = w_r + w_k;
  assign w_sh_n       = {r_n, 3'b000};
  assign w_sh_r       = {w_r, 3'b000};
  assign w_din_m      = data_in & f_bits(keep_in);
  // residue followed by the first N bytes of this beat
  assign w_join       = r_res | (w_din_m >> w_sh_r);
  // bytes of this beat that follow its first N bytes, moved to the MSB end
  assign w_tail       = w_din_m << w_sh_n;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) w_k = w_k + {{BYTE_CNT_WD{1'b0}}, keep_in[i]};
  end

  // What, if anything, is loaded into the output register this cycle
  always_comb begin
    w_emit  = 1'b0;
    w_odata = '0;
    w_okeep = '0;
    w_olast = 1'b0;
    case (r_state)
      S_FIRST, S_STREAM: begin
        if (w_in_fire) begin
          if (r_n == '0) begin
            // nothing to strip: straight registered pass-through
            w_emit  = 1'b1;
            w_odata = w_din_m;
            w_okeep = f_keep(w_k);
            w_olast = last_in;
          end else if (r_state == S_FIRST) begin
            if (last_in && (w_k > r_n)) begin
              w_emit  = 1'b1;
              w_odata = w_tail;
              w_okeep = f_keep(w_k - r_n);
              w_olast = 1'b1;
            end
          end else if (!last_in || (w_k > r_n)) begin
            // full beat; a last beat with k>N leaves a flush beat behind
            w_emit  = 1'b1;
            w_odata = w_join;
            w_okeep = {DATA_BYTE_WD{1'b1}};
          end else if (w_sum != '0) begin
            w_emit  = 1'b1;
            w_odata = w_join;
            w_okeep = f_keep(w_sum);
            w_olast = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_emit  = 1'b1;
          w_odata = r_flush_data;
          w_okeep = r_flush_keep;
          w_olast = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_n            <= '0;
      r_res          <= '0;
      r_flush_data   <= '0;
      r_flush_keep   <= '0;
      r_valid_out    <= 1'b0;
      r_data_out     <= '0;
      r_keep_out     <= '0;
      r_last_out     <= 1'b0;
`ifdef HEADER_CAPTURE_EN
      r_header       <= '0;
      r_header_valid <= 1'b0;
`endif
    end else begin
      if (w_out_free) begin
        r_valid_out <= w_emit;
        r_data_out  <= w_odata;
        r_keep_out  <= w_okeep;
        r_last_out  <= w_olast;
      end
`ifdef HEADER_CAPTURE_EN
      r_header_valid <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (valid_remove) begin
            r_n     <= w_n_clamp;
            r_state <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (w_in_fire) begin
            r_res   <= w_tail;
            r_state <= last_in ? S_IDLE : S_STREAM;
`ifdef HEADER_CAPTURE_EN
            r_header       <= data_in & f_bits(f_keep(r_n));
            r_header_valid <= 1'b1;
`endif
          end
        end
        S_STREAM: begin
          if (w_in_fire) begin
            r_res <= w_tail;
            if (last_in) begin
              if ((r_n != '0) && (w_k > r_n)) begin
                r_flush_data <= w_tail;
                r_flush_keep <= f_keep(w_k - r_n);
                r_state      <= S_FLUSH;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_FLUSH: begin
          if (w_out_free) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign keep_out  = r_keep_out;
  assign last_out  = r_last_out;
`ifdef HEADER_CAPTURE_EN
  assign header_out   = r_header;
  assign header_valid = r_header_valid;
`endif

endmodule
